// File: rtl/hnf_mshr_alloc_qos_pkg.sv
// Shared definitions for the HN-F MSHR allocator: default MSHR sizing,
// CHI field widths and the grant FSM state encoding.
package hnf_mshr_alloc_qos_pkg;

  localparam int HNF_MSHR_ENTRIES_NUM   = 32;
  localparam int HNF_MSHR_ENTRIES_WIDTH = 5;
  localparam int HNF_RSV_HP_NUM         = 4;
  localparam int HNF_HP_QOS_THRESHOLD   = 12;
  localparam int HNF_RETRY_FIFO_DEPTH   = 16;

  localparam int CHI_SRCID_W = 11;
  localparam int CHI_TXNID_W = 12;
  localparam int CHI_QOS_W   = 4;

  typedef enum logic {
    GNT_IDLE = 1'b0,
    GNT_WAIT = 1'b1
  } gnt_state_e;

endpackage

// File: rtl/hnf_mshr_alloc_qos_retry_fifo.sv
// hnf_mshr_retry_fifo: small srcid queue used to remember retried requesters
// until a P-Credit can be granted. Pushes into a full queue and pops from an
// empty queue are ignored. Storage is not reset; only the pointers are.
module hnf_mshr_retry_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Entry storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hnf_mshr_alloc_qos.sv
// hnf_mshr_alloc_qos: MSHR entry allocator with Retry / P-Credit management.
// A valid s0 request gets the lowest free entry (s1 alloc pulse) or a RetryAck
// (s1 retry pulse) and its srcid is queued; queued requesters later receive a
// PCrdGrant once an entry is available, and credit re-sends always allocate.
// Build option: define HNF_MSHR_HP_RSV_EN to enable the high-priority class
// (RSV_HP_NUM entries held back from normal requests, separate HP retry queue
// with grant priority). Without it there is a single class and a single queue.
module hnf_mshr_alloc_qos
  import hnf_mshr_alloc_qos_pkg::*;
#(
  parameter int MSHR_ENTRIES_NUM   = HNF_MSHR_ENTRIES_NUM,
  parameter int MSHR_ENTRIES_WIDTH = HNF_MSHR_ENTRIES_WIDTH,
  parameter int RSV_HP_NUM         = HNF_RSV_HP_NUM,
  parameter int HP_QOS_THRESHOLD   = HNF_HP_QOS_THRESHOLD,
  parameter int RETRY_FIFO_DEPTH   = HNF_RETRY_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          li_mshr_rxreq_valid_s0,
  input  logic [CHI_QOS_W-1:0]          li_mshr_rxreq_qos_s0,
  input  logic                          li_mshr_rxreq_allowretry_s0,
  input  logic [CHI_SRCID_W-1:0]        li_mshr_rxreq_srcid_s0,
  input  logic [CHI_TXNID_W-1:0]        li_mshr_rxreq_txnid_s0,
  input  logic                          mshr_dbf_retired_valid_sx1_q,
  input  logic [MSHR_ENTRIES_WIDTH-1:0] mshr_dbf_retired_idx_sx1_q,
  output logic                          mshr_alloc_en_s1_q,
  output logic [MSHR_ENTRIES_WIDTH-1:0] mshr_entry_idx_alloc_s1_q,
  output logic [MSHR_ENTRIES_NUM-1:0]   mshr_entry_alloc_s1_q,
  output logic                          qos_retry_valid_s1_q,
  output logic [CHI_SRCID_W-1:0]        qos_retry_srcid_s1_q,
  output logic [CHI_TXNID_W-1:0]        qos_retry_txnid_s1_q,
  output logic                          qos_pcrdgnt_valid_q,
  output logic [CHI_SRCID_W-1:0]        qos_pcrdgnt_srcid_q,
  input  logic                          txrsp_qos_pcrdgnt_ready
);

  localparam int N  = MSHR_ENTRIES_NUM;
  localparam int W  = MSHR_ENTRIES_WIDTH;
  localparam int CW = MSHR_ENTRIES_WIDTH + 1;

  localparam logic [CW-1:0] ENTRIES_C = CW'(MSHR_ENTRIES_NUM);
`ifdef HNF_MSHR_HP_RSV_EN
  localparam logic [CW-1:0] NORM_THR  = CW'(RSV_HP_NUM);
`else
  localparam logic [CW-1:0] NORM_THR  = '0;
`endif

  // Elaboration-time sanity on the configuration.
  if (MSHR_ENTRIES_NUM > (1 << MSHR_ENTRIES_WIDTH)) begin : g_chk_width
    $error("MSHR_ENTRIES_WIDTH too small for MSHR_ENTRIES_NUM");
  end
  if (RSV_HP_NUM >= MSHR_ENTRIES_NUM) begin : g_chk_rsv
    $error("RSV_HP_NUM must be below MSHR_ENTRIES_NUM");
  end
  if (HP_QOS_THRESHOLD > 15) begin : g_chk_qos
    $error("HP_QOS_THRESHOLD does not fit the QoS field");
  end
  if (RETRY_FIFO_DEPTH < 1) begin : g_chk_fifo
    $error("RETRY_FIFO_DEPTH must be at least 1");
  end

  logic [N-1:0]           free_map;
  logic [N-1:0]           free_map_nxt;
  logic [CW-1:0]          free_cnt;
  logic [CW-1:0]          rsv_cnt;
  logic [CW-1:0]          avail;
  logic [CW-1:0]          avail_g;
  logic [W-1:0]           pick;
  logic [N-1:0]           pick_oh;
  logic [N-1:0]           retire_oh;
  logic                   req_hp;
  logic                   alloc_s0;
  logic                   retry_s0;
  logic                   rsv_dec;
  logic                   push_hp;
  logic                   push_nrm;
  logic                   pop_hp;
  logic                   pop_nrm;
  logic                   hp_full;
  logic                   hp_empty;
  logic [CHI_SRCID_W-1:0] hp_head;
  logic                   nrm_full;
  logic                   nrm_empty;
  logic [CHI_SRCID_W-1:0] nrm_head;
  gnt_state_e             gnt_state;
  gnt_state_e             gnt_state_nxt;

  function automatic logic [W-1:0] lowest_free(input logic [N-1:0] map);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (map[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // Saturating decrement: a credit re-send may allocate while avail is 0,
  // and wrapping would let the grant logic hand out a credit that has no entry.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v, input logic dec);
    return (dec && (v != '0)) ? v - 1'b1 : v;
  endfunction

  assign avail     = free_cnt - rsv_cnt;
  assign avail_g   = sat_dec(avail, alloc_s0);
  assign pick      = lowest_free(free_map);
  assign pick_oh   = alloc_s0 ? (N'(1) << pick) : '0;
  assign retire_oh = mshr_dbf_retired_valid_sx1_q ? (N'(1) << mshr_dbf_retired_idx_sx1_q) : '0;
  assign free_map_nxt = (free_map & ~pick_oh) | retire_oh;

`ifdef HNF_MSHR_HP_RSV_EN
  assign req_hp = (li_mshr_rxreq_qos_s0 >= CHI_QOS_W'(HP_QOS_THRESHOLD));

  hnf_mshr_retry_fifo #(
    .DEPTH  (RETRY_FIFO_DEPTH),
    .DATA_W (CHI_SRCID_W)
  ) u_hp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_hp),
    .push_data (li_mshr_rxreq_srcid_s0),
    .pop       (pop_hp),
    .full      (hp_full),
    .empty     (hp_empty),
    .head      (hp_head)
  );
`else
  logic unused_qos;
  assign unused_qos = ^li_mshr_rxreq_qos_s0;
  assign req_hp     = 1'b0;
  assign hp_full    = 1'b0;
  assign hp_empty   = 1'b1;
  assign hp_head    = '0;
`endif

  hnf_mshr_retry_fifo #(
    .DEPTH  (RETRY_FIFO_DEPTH),
    .DATA_W (CHI_SRCID_W)
  ) u_nrm_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_nrm),
    .push_data (li_mshr_rxreq_srcid_s0),
    .pop       (pop_nrm),
    .full      (nrm_full),
    .empty     (nrm_empty),
    .head      (nrm_head)
  );

  // s0 decision: allocate, retry (and queue the requester), or drop on protocol error.
  always_comb begin
    alloc_s0 = 1'b0;
    retry_s0 = 1'b0;
    rsv_dec  = 1'b0;
    push_hp  = 1'b0;
    push_nrm = 1'b0;
    if (li_mshr_rxreq_valid_s0) begin
      if (!li_mshr_rxreq_allowretry_s0) begin
        alloc_s0 = (free_cnt != '0);
        rsv_dec  = alloc_s0 && (rsv_cnt != '0);
      end else if (req_hp) begin
        if (avail != '0) begin
          alloc_s0 = 1'b1;
        end else begin
          retry_s0 = 1'b1;
          push_hp  = !hp_full;
        end
      end else begin
        if (avail > NORM_THR) begin
          alloc_s0 = 1'b1;
        end else begin
          retry_s0 = 1'b1;
          push_nrm = !nrm_full;
        end
      end
    end
  end

  // Grant FSM next state: pop a queued requester when an entry can be promised.
  always_comb begin
    gnt_state_nxt = gnt_state;
    pop_hp        = 1'b0;
    pop_nrm       = 1'b0;
    case (gnt_state)
      GNT_IDLE: begin
        if (!hp_empty && (avail_g != '0)) begin
          pop_hp        = 1'b1;
          gnt_state_nxt = GNT_WAIT;
        end else if (!nrm_empty && (avail_g > NORM_THR)) begin
          pop_nrm       = 1'b1;
          gnt_state_nxt = GNT_WAIT;
        end
      end
      GNT_WAIT: begin
        if (txrsp_qos_pcrdgnt_ready) gnt_state_nxt = GNT_IDLE;
      end
      default: gnt_state_nxt = GNT_IDLE;
    endcase
  end

  // Entry bitmap, counters and grant state.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_map  <= '1;
      free_cnt  <= ENTRIES_C;
      rsv_cnt   <= '0;
      gnt_state <= GNT_IDLE;
    end else begin
      free_map  <= free_map_nxt;
      free_cnt  <= free_cnt + CW'(mshr_dbf_retired_valid_sx1_q) - CW'(alloc_s0);
      rsv_cnt   <= rsv_cnt + CW'(pop_hp | pop_nrm) - CW'(rsv_dec);
      gnt_state <= gnt_state_nxt;
    end
  end

  // s0 -> s1 boundary: single-cycle alloc and retry pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mshr_alloc_en_s1_q        <= 1'b0;
      mshr_entry_idx_alloc_s1_q <= '0;
      mshr_entry_alloc_s1_q     <= '0;
      qos_retry_valid_s1_q      <= 1'b0;
      qos_retry_srcid_s1_q      <= '0;
      qos_retry_txnid_s1_q      <= '0;
    end else begin
      mshr_alloc_en_s1_q        <= alloc_s0;
      mshr_entry_idx_alloc_s1_q <= alloc_s0 ? pick : '0;
      mshr_entry_alloc_s1_q     <= pick_oh;
      qos_retry_valid_s1_q      <= retry_s0;
      qos_retry_srcid_s1_q      <= retry_s0 ? li_mshr_rxreq_srcid_s0 : '0;
      qos_retry_txnid_s1_q      <= retry_s0 ? li_mshr_rxreq_txnid_s0 : '0;
    end
  end

  // PCrdGrant request register: set on a pop, held until txrsp accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      qos_pcrdgnt_valid_q <= 1'b0;
      qos_pcrdgnt_srcid_q <= '0;
    end else if (pop_hp || pop_nrm) begin
      qos_pcrdgnt_valid_q <= 1'b1;
      qos_pcrdgnt_srcid_q <= pop_hp ? hp_head : nrm_head;
    end else if ((gnt_state == GNT_WAIT) && txrsp_qos_pcrdgnt_ready) begin
      qos_pcrdgnt_valid_q <= 1'b0;
      qos_pcrdgnt_srcid_q <= '0;
    end
  end

endmodule

// File: tb/tb_hnf_mshr_alloc_qos.sv
// Self-checking bench for hnf_mshr_alloc_qos. s1 results are predicted into a
// scoreboard queue when each request is driven and compared by a monitor when
// the due cycle arrives; grant, counter and reset behaviour is checked in the
// scenario tasks. Expectations follow HNF_MSHR_HP_RSV_EN when it is defined.
module tb_hnf_mshr_alloc_qos;

`ifdef HNF_MSHR_HP_RSV_EN
  localparam int RSV = 4;
`else
  localparam int RSV = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [3:0]  qos = '0;
  logic        allowretry = 1'b1;
  logic [10:0] srcid = '0;
  logic [11:0] txnid = '0;
  logic        ret_valid = 1'b0;
  logic [4:0]  ret_idx = '0;
  logic        alloc_en;
  logic [4:0]  alloc_idx;
  logic [31:0] alloc_oh;
  logic        retry_valid;
  logic [10:0] retry_srcid;
  logic [11:0] retry_txnid;
  logic        gnt_valid;
  logic [10:0] gnt_srcid;
  logic        gnt_ready = 1'b0;

  hnf_mshr_alloc_qos dut (
    .clk                          (clk),
    .rst                          (rst),
    .li_mshr_rxreq_valid_s0       (valid),
    .li_mshr_rxreq_qos_s0         (qos),
    .li_mshr_rxreq_allowretry_s0  (allowretry),
    .li_mshr_rxreq_srcid_s0       (srcid),
    .li_mshr_rxreq_txnid_s0       (txnid),
    .mshr_dbf_retired_valid_sx1_q (ret_valid),
    .mshr_dbf_retired_idx_sx1_q   (ret_idx),
    .mshr_alloc_en_s1_q           (alloc_en),
    .mshr_entry_idx_alloc_s1_q    (alloc_idx),
    .mshr_entry_alloc_s1_q        (alloc_oh),
    .qos_retry_valid_s1_q         (retry_valid),
    .qos_retry_srcid_s1_q         (retry_srcid),
    .qos_retry_txnid_s1_q         (retry_txnid),
    .qos_pcrdgnt_valid_q          (gnt_valid),
    .qos_pcrdgnt_srcid_q          (gnt_srcid),
    .txrsp_qos_pcrdgnt_ready      (gnt_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          alloc;
    int          idx;
    logic [10:0] src;
    logic [11:0] txn;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compare s1 outputs against the prediction due this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      n_total++;
      if (alloc_en !== mon_e.alloc) $display("FAIL s1_alloc_en cyc=%0d got %b expected %b", cyc, alloc_en, mon_e.alloc);
      else n_pass++;
      n_total++;
      if (retry_valid !== !mon_e.alloc) $display("FAIL s1_retry_valid cyc=%0d got %b expected %b", cyc, retry_valid, !mon_e.alloc);
      else n_pass++;
      if (mon_e.alloc) begin
        n_total++;
        if (alloc_idx !== 5'(mon_e.idx)) $display("FAIL s1_alloc_idx cyc=%0d got %0d expected %0d", cyc, alloc_idx, mon_e.idx);
        else n_pass++;
        n_total++;
        if (alloc_oh !== (32'd1 << mon_e.idx)) $display("FAIL s1_alloc_onehot cyc=%0d got %h expected %h", cyc, alloc_oh, 32'd1 << mon_e.idx);
        else n_pass++;
      end else begin
        n_total++;
        if (retry_srcid !== mon_e.src) $display("FAIL s1_retry_srcid cyc=%0d got %h expected %h", cyc, retry_srcid, mon_e.src);
        else n_pass++;
        n_total++;
        if (retry_txnid !== mon_e.txn) $display("FAIL s1_retry_txnid cyc=%0d got %h expected %h", cyc, retry_txnid, mon_e.txn);
        else n_pass++;
      end
    end else begin
      n_total++;
      if (alloc_en !== 1'b0 || retry_valid !== 1'b0)
        $display("FAIL s1_unexpected cyc=%0d got alloc=%b retry=%b expected none", cyc, alloc_en, retry_valid);
      else n_pass++;
    end
  end

  task automatic step(input bit rv, input bit ar, input logic [3:0] q, input logic [10:0] s,
                      input logic [11:0] t, input bit ea, input int eidx,
                      input bit rtv, input int ridx);
    valid      = rv;
    allowretry = ar;
    qos        = q;
    srcid      = s;
    txnid      = t;
    ret_valid  = rtv;
    ret_idx    = 5'(ridx);
    if (rv) exp_q.push_back('{due: cyc + 1, alloc: ea, idx: eidx, src: s, txn: t});
    @(posedge clk);
    #1;
    valid     = 1'b0;
    ret_valid = 1'b0;
  endtask

  task automatic req(input bit ar, input logic [3:0] q, input logic [10:0] s,
                     input logic [11:0] t, input bit ea, input int eidx);
    step(1'b1, ar, q, s, t, ea, eidx, 1'b0, 0);
  endtask

  task automatic retire(input int ridx);
    step(1'b0, 1'b1, 4'h0, 11'h0, 12'h0, 1'b0, 0, 1'b1, ridx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'h0, 11'h0, 12'h0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    valid     = 1'b0;
    ret_valid = 1'b0;
    gnt_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Entries 0..27 with normal QoS, the rest high-priority so the reserve is usable.
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) req(1'b1, (i < 28) ? 4'h0 : 4'hF, 11'(i), 12'(i), 1'b1, i);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({alloc_en, alloc_idx, alloc_oh, retry_valid, retry_srcid, retry_txnid, gnt_valid, gnt_srcid} !== '0)
      $display("FAIL reset_outputs got alloc=%b retry=%b gnt=%b expected all zero", alloc_en, retry_valid, gnt_valid);
    else n_pass++;
    n_total++;
    if (dut.free_cnt !== 6'd32) $display("FAIL reset_free_cnt got %0d expected 32", dut.free_cnt);
    else n_pass++;
    n_total++;
    if (dut.rsv_cnt !== 6'd0) $display("FAIL reset_rsv_cnt got %0d expected 0", dut.rsv_cnt);
    else n_pass++;
  endtask

  task automatic test_alloc_order();
    do_reset();
    req(1'b1, 4'h0, 11'h010, 12'h100, 1'b1, 0);
    req(1'b1, 4'h0, 11'h011, 12'h101, 1'b1, 1);
    req(1'b1, 4'h0, 11'h012, 12'h102, 1'b1, 2);
    retire(1);
    req(1'b1, 4'h0, 11'h013, 12'h103, 1'b1, 1);
    idle(1);
  endtask

  task automatic test_fill_retry();
    do_reset();
`ifdef HNF_MSHR_HP_RSV_EN
    fill(28);
    req(1'b1, 4'h0, 11'h005, 12'h0AB, 1'b0, 0);
    req(1'b1, 4'hC, 11'h020, 12'h200, 1'b1, 28);
    for (int i = 29; i < 32; i++) req(1'b1, 4'hF, 11'(i), 12'(i), 1'b1, i);
`else
    fill(32);
    req(1'b1, 4'h0, 11'h005, 12'h0AB, 1'b0, 0);
`endif
    idle(1);
    n_total++;
    if (dut.free_cnt !== 6'd0) $display("FAIL fill_free_cnt got %0d expected 0", dut.free_cnt);
    else n_pass++;
  endtask

  task automatic test_grant();
    for (int i = 0; i < RSV; i++) retire(i);
    retire(RSV);
    n_total++;
    if (gnt_valid !== 1'b0) $display("FAIL grant_early got %b expected 0", gnt_valid);
    else n_pass++;
    idle(1);
    n_total++;
    if (gnt_valid !== 1'b1 || gnt_srcid !== 11'h005)
      $display("FAIL grant_n2 got valid=%b srcid=%h expected valid=1 srcid=005", gnt_valid, gnt_srcid);
    else n_pass++;
    n_total++;
    if (dut.rsv_cnt !== 6'd1) $display("FAIL grant_rsv_cnt got %0d expected 1", dut.rsv_cnt);
    else n_pass++;
    gnt_ready = 1'b1;
    idle(1);
    gnt_ready = 1'b0;
    n_total++;
    if (gnt_valid !== 1'b0) $display("FAIL grant_drop got %b expected 0", gnt_valid);
    else n_pass++;
  endtask

  task automatic test_credit_use();
    req(1'b0, 4'h0, 11'h005, 12'h0CD, 1'b1, 0);
    n_total++;
    if (dut.rsv_cnt !== 6'd0) $display("FAIL credit_rsv_cnt got %0d expected 0", dut.rsv_cnt);
    else n_pass++;
    n_total++;
    if (dut.free_cnt !== 6'(RSV)) $display("FAIL credit_free_cnt got %0d expected %0d", dut.free_cnt, RSV);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_priority();
    logic [10:0] first;
`ifdef HNF_MSHR_HP_RSV_EN
    first = 11'h007;
`else
    first = 11'h003;
`endif
    do_reset();
    fill(32);
    req(1'b1, 4'h0, 11'h003, 12'h031, 1'b0, 0);
    req(1'b1, 4'hF, 11'h007, 12'h071, 1'b0, 0);
    retire(5);
    n_total++;
    if (gnt_valid !== 1'b0) $display("FAIL prio_early got %b expected 0", gnt_valid);
    else n_pass++;
    idle(1);
    n_total++;
    if (gnt_valid !== 1'b1 || gnt_srcid !== first)
      $display("FAIL prio_grant got valid=%b srcid=%h expected valid=1 srcid=%h", gnt_valid, gnt_srcid, first);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      n_total++;
      if (gnt_valid !== 1'b1 || gnt_srcid !== first)
        $display("FAIL prio_hold%0d got valid=%b srcid=%h expected valid=1 srcid=%h", k, gnt_valid, gnt_srcid, first);
      else n_pass++;
    end
    n_total++;
    if (dut.rsv_cnt !== 6'd1) $display("FAIL prio_rsv_cnt got %0d expected 1", dut.rsv_cnt);
    else n_pass++;
    gnt_ready = 1'b1;
    idle(1);
    n_total++;
    if (gnt_valid !== 1'b0) $display("FAIL prio_drop got %b expected 0", gnt_valid);
    else n_pass++;
    idle(2);
    n_total++;
    if (gnt_valid !== 1'b0) $display("FAIL prio_no_second got %b expected 0", gnt_valid);
    else n_pass++;
    gnt_ready = 1'b0;
    retire(6);
    idle(1);
    n_total++;
`ifdef HNF_MSHR_HP_RSV_EN
    if (gnt_valid !== 1'b0) $display("FAIL prio_normal_held got valid=%b expected 0", gnt_valid);
    else n_pass++;
`else
    if (gnt_valid !== 1'b1 || gnt_srcid !== 11'h007)
      $display("FAIL prio_second got valid=%b srcid=%h expected valid=1 srcid=007", gnt_valid, gnt_srcid);
    else n_pass++;
`endif
    gnt_ready = 1'b1;
    idle(1);
    gnt_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    fill(31);
    n_total++;
    if (dut.free_cnt !== 6'd1) $display("FAIL simul_pre_free got %0d expected 1", dut.free_cnt);
    else n_pass++;
    step(1'b1, 1'b1, 4'hF, 11'h02A, 12'h2A0, 1'b1, 31, 1'b1, 10);
    n_total++;
    if (dut.free_cnt !== 6'd1) $display("FAIL simul_free_cnt got %0d expected 1", dut.free_cnt);
    else n_pass++;
    req(1'b1, 4'hF, 11'h02B, 12'h2B0, 1'b1, 10);
    n_total++;
    if (dut.free_cnt !== 6'd0) $display("FAIL simul_post_free got %0d expected 0", dut.free_cnt);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill(32);
    req(1'b1, 4'hF, 11'h009, 12'h009, 1'b0, 0);
    retire(0);
    idle(1);
    n_total++;
    if (gnt_valid !== 1'b1 || gnt_srcid !== 11'h009)
      $display("FAIL rstmid_wait got valid=%b srcid=%h expected valid=1 srcid=009", gnt_valid, gnt_srcid);
    else n_pass++;
    rst        = 1'b1;
    valid      = 1'b1;
    allowretry = 1'b1;
    srcid      = 11'h01F;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    n_total++;
    if ({alloc_en, alloc_idx, alloc_oh, retry_valid, retry_srcid, retry_txnid, gnt_valid, gnt_srcid} !== '0)
      $display("FAIL rstmid_outputs got alloc=%b retry=%b gnt=%b expected all zero", alloc_en, retry_valid, gnt_valid);
    else n_pass++;
    n_total++;
    if (dut.free_cnt !== 6'd32 || dut.rsv_cnt !== 6'd0)
      $display("FAIL rstmid_counts got free=%0d rsv=%0d expected free=32 rsv=0", dut.free_cnt, dut.rsv_cnt);
    else n_pass++;
    req(1'b1, 4'h0, 11'h012, 12'h012, 1'b1, 0);
    idle(2);
    n_total++;
    if (gnt_valid !== 1'b0) $display("FAIL rstmid_queue_flushed got %b expected 0", gnt_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alloc_order();
    test_fill_retry();
    test_grant();
    test_credit_use();
    test_priority();
    test_simultaneous();
    test_reset_mid();
    idle(2);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
